// File: rtl/witness_search_ctrl.sv
// Witness search sequencer: walks candidate i vectors upward against one formula evaluator until out==1.
// Optional build macro WITNESS_SEARCH_PIPE_EN registers the evaluator result (1-cycle evaluator latency).
module witness_search_ctrl #(
  parameter int NX = 4,
  parameter int NI = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [NX-1:0] x_in,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [NI-1:0] witness,
  output logic [NI:0]   eval_cnt,
  output logic [NX-1:0] fml_x,
  output logic [NI-1:0] fml_i,
  input  logic          fml_out
);

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } state_t;

  localparam logic [NI-1:0] CAND_MAX = '1;

  state_t state;

`ifdef WITNESS_SEARCH_PIPE_EN
  // Result pipeline: res_* describe the candidate whose registered answer is visible this cycle.
  logic          issue_en;
  logic          res_vld;
  logic          res_out;
  logic [NI-1:0] res_cand;
`endif

  // NOTE: every register here uses non-blocking assignments so all state updates
  // see the pre-edge values; a later assignment in the same branch overrides an earlier one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      witness  <= '0;
      eval_cnt <= '0;
      fml_x    <= '0;
      fml_i    <= '0;
`ifdef WITNESS_SEARCH_PIPE_EN
      issue_en <= 1'b0;
      res_vld  <= 1'b0;
      res_out  <= 1'b0;
      res_cand <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            fml_x    <= x_in;
            fml_i    <= '0;
            found    <= 1'b0;
            witness  <= '0;
            eval_cnt <= '0;
            busy     <= 1'b1;
            state    <= SEARCH;
`ifdef WITNESS_SEARCH_PIPE_EN
            issue_en <= 1'b1;
            res_vld  <= 1'b0;
`endif
          end
        end

        SEARCH: begin
          if (abort) begin
            busy  <= 1'b0;
            found <= 1'b0;
            state <= IDLE;
`ifdef WITNESS_SEARCH_PIPE_EN
            issue_en <= 1'b0;
            res_vld  <= 1'b0;
`endif
          end else begin
`ifdef WITNESS_SEARCH_PIPE_EN
            res_vld  <= issue_en;
            res_out  <= fml_out;
            res_cand <= fml_i;
            if (issue_en) begin
              if (fml_i == CAND_MAX) issue_en <= 1'b0;
              else                   fml_i    <= fml_i + 1'b1;
            end
            if (res_vld) begin
              eval_cnt <= eval_cnt + 1'b1;
              // A hit on the delayed candidate wins; the newer issued candidate is dropped uncounted.
              if (res_out) begin
                witness  <= res_cand;
                found    <= 1'b1;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
                issue_en <= 1'b0;
                res_vld  <= 1'b0;
              end else if (res_cand == CAND_MAX) begin
                found    <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
                issue_en <= 1'b0;
                res_vld  <= 1'b0;
              end
            end
`else
            eval_cnt <= eval_cnt + 1'b1;
            if (fml_out) begin
              witness <= fml_i;
              found   <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else if (fml_i == CAND_MAX) begin
              found <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              fml_i <= fml_i + 1'b1;
            end
`endif
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_witness_search_ctrl.sv
// Self-checking bench for witness_search_ctrl: directed steps, expected results queued per search.
// Bench evaluator: mode 0 hits when i[3:0]==x+1 (mod 16), mode 1 never hits, mode 2 hits only at target.
module tb_witness_search_ctrl;

  localparam int NX = 4;
  localparam int NI = 9;
`ifdef WITNESS_SEARCH_PIPE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [NX-1:0] x_in;
  logic          busy;
  logic          done;
  logic          found;
  logic [NI-1:0] witness;
  logic [NI:0]   eval_cnt;
  logic [NX-1:0] fml_x;
  logic [NI-1:0] fml_i;
  logic          fml_out;

  int            eval_mode;
  logic [NI-1:0] target;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          found;
    logic [NI-1:0] witness;
    logic [NI:0]   cnt;
    int            cyc;
  } exp_t;

  exp_t sb[$];

  function automatic logic model_eval(logic [NX-1:0] x, logic [NI-1:0] i, int mode,
                                      logic [NI-1:0] tgt);
    logic [3:0] xp1;
    xp1 = x + 4'd1;
    case (mode)
      1:       return 1'b0;
      2:       return i == tgt;
      default: return i[3:0] == xp1;
    endcase
  endfunction

  assign fml_out = model_eval(fml_x, fml_i, eval_mode, target);

  witness_search_ctrl #(.NX(NX), .NI(NI)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .x_in     (x_in),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .witness  (witness),
    .eval_cnt (eval_cnt),
    .fml_x    (fml_x),
    .fml_i    (fml_i),
    .fml_out  (fml_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expected(input logic [NX-1:0] x);
    exp_t e;
    int   hit;
    hit = -1;
    for (int k = 0; k < 2 ** NI; k++) begin
      if (hit < 0 && model_eval(x, k[NI-1:0], eval_mode, target)) hit = k;
    end
    if (hit >= 0) begin
      e.found   = 1'b1;
      e.witness = hit[NI-1:0];
      e.cnt     = hit[NI:0] + 1'b1;
      e.cyc     = hit + 2 + LAT;
    end else begin
      e.found   = 1'b0;
      e.witness = '0;
      e.cnt     = (NI+1)'(2 ** NI);
      e.cyc     = 2 ** NI + 1 + LAT;
    end
    sb.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},     32'(busy),     32'd0);
    check({tag, " done"},     32'(done),     32'd0);
    check({tag, " found"},    32'(found),    32'd0);
    check({tag, " witness"},  32'(witness),  32'd0);
    check({tag, " eval_cnt"}, 32'(eval_cnt), 32'd0);
    check({tag, " fml_x"},    32'(fml_x),    32'd0);
    check({tag, " fml_i"},    32'(fml_i),    32'd0);
  endtask

  // Drives start through edge E0; returns at the negedge of cycle 1.
  task automatic launch(input logic [NX-1:0] x, input logic with_abort);
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    x_in  = x;
    push_expected(x);
    @(posedge clk);
    #1;
    check("busy in cycle 1",  32'(busy),  32'd1);
    check("fml_i in cycle 1", 32'(fml_i), 32'd0);
    check("fml_x captured",   32'(fml_x), 32'(x));
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    x_in  = NX'($urandom);
  endtask

  // Called at the negedge of cycle 1; optionally pulses a start that must be ignored.
  task automatic wait_done(input logic do_ignore, input logic [NX-1:0] ignore_x);
    exp_t          e;
    int            cyc;
    bit            seen;
    logic [NX-1:0] x_orig;
    cyc    = 1;
    seen   = 1'b0;
    x_orig = fml_x;
    for (int n = 0; n < 1100 && !seen; n++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (do_ignore && cyc == 3) begin
          start = 1'b1;
          x_in  = ignore_x;
        end
        if (do_ignore && cyc == 4) begin
          start = 1'b0;
          check("fml_x held on ignored start", 32'(fml_x), 32'(x_orig));
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    e = sb.pop_front();
    check("done within bound", 32'(seen), 32'd1);
    if (seen) begin
      check("done cycle", 32'(cyc),       32'(e.cyc));
      check("found",      32'(found),     32'(e.found));
      check("witness",    32'(witness),   32'(e.witness));
      check("eval_cnt",   32'(eval_cnt),  32'(e.cnt));
      check("busy at done", 32'(busy),    32'd0);
      @(negedge clk);
      check("done is one pulse", 32'(done), 32'd0);
      check("found held",        32'(found), 32'(e.found));
    end
    @(negedge clk);
  endtask

  task automatic wait_cand(input logic [NI-1:0] value, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 1100 && !ok; n++) begin
      @(negedge clk);
      if (fml_i == value && busy) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    int done_seen;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    x_in      = '0;
    eval_mode = 0;
    target    = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Formula search, x=0: first hit at candidate 1
    launch(4'h0, 1'b0);
    wait_done(1'b0, '0);

    // Boundary: hit at candidate 0
    launch(4'hF, 1'b0);
    wait_done(1'b0, '0);

    // Start during SEARCH with another x is ignored
    launch(4'h5, 1'b0);
    wait_done(1'b1, 4'h9);

    // Abort in IDLE is ignored: last result stays
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort in idle busy",  32'(busy),    32'd0);
    check("abort in idle found", 32'(found),   32'd1);
    check("abort in idle wit",   32'(witness), 32'h6);

    // Exhaustive no-witness search
    eval_mode = 1;
    launch(4'h3, 1'b0);
    wait_done(1'b0, '0);

    // Boundary: hit on the last candidate
    eval_mode = 2;
    target    = 9'h1FF;
    launch(4'h2, 1'b0);
    wait_done(1'b0, '0);

    // Abort at candidate 10
    eval_mode = 1;
    launch(4'h7, 1'b0);
    void'(sb.pop_front());
    wait_cand(9'd10, ok);
    check("reached cand 10", 32'(ok), 32'd1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    check("busy after abort",  32'(busy),  32'd0);
    check("found after abort", 32'(found), 32'd0);
    @(negedge clk);
    abort     = 1'b0;
    done_seen = 0;
    for (int n = 0; n < 8; n++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("no done after abort", 32'(done_seen), 32'd0);

    // Restart with start and abort together: start wins, search from cand 0
    eval_mode = 0;
    launch(4'h3, 1'b1);
    wait_done(1'b0, '0);

    // Reset mid-search at candidate 37
    eval_mode = 1;
    launch(4'hA, 1'b0);
    void'(sb.pop_front());
    wait_cand(9'd37, ok);
    check("reached cand 37", 32'(ok), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle after reset busy", 32'(busy), 32'd0);
    check("idle after reset done", 32'(done), 32'd0);

    // Search after reset behaves normally
    eval_mode = 0;
    launch(4'h0, 1'b0);
    wait_done(1'b0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
